// File: rtl/output_port_ctrl.sv
// Router output-port controller: round-robin grant of input requests,
// PORT_FREE/PORT_BUSY advertisement, 2-entry skid FIFO and credit-gated link.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_outport_req   per-input-port request bits for this output
//   o_outport_ack   registered one-hot grant pulse (one cycle)
//   o_port_status   PORT_FREE / PORT_BUSY back to the switch
//   i_s2o           crossbar flit for this output port
//   i_credit_ret    downstream freed one buffer slot
//   o_flit          registered link flit (invalid_flit() when idle)
//   o_flit_valid    o_flit carries a real flit
//   o_ovf_err       sticky: flit arrived while the FIFO was full

package router_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        INVALID_FLIT,
        HEAD_FLIT,
        BODY_FLIT,
        TAIL_FLIT,
        HEADTAIL_FLIT
    } flit_type_t;

    typedef struct packed {
        flit_type_t  flit_type;
        logic [31:0] payload;
    } flit_tail_t;

    typedef struct packed {
        flit_tail_t tail;
    } flit_t;

    typedef struct packed {
        flit_t flit;
    } router_pipeline_bus_t;

    typedef enum logic {
        PORT_FREE,
        PORT_BUSY
    } port_status_t;

    typedef struct packed {
        port_status_t port_status;
    } OUT_PORT_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } opc_state_t;

    function automatic router_pipeline_bus_t invalid_flit();
        router_pipeline_bus_t f;
        f = '0;
        f.flit.tail.flit_type = INVALID_FLIT;
        return f;
    endfunction

endpackage

module output_port_ctrl
    import router_pkg::*;
#(
    parameter int NUM_OF_PORTS = NUM_PORTS,
    parameter int PORT_ID      = 0,
    parameter int CREDITS      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_OF_PORTS-1:0] i_outport_req,
    output logic [NUM_OF_PORTS-1:0] o_outport_ack,
    output OUT_PORT_t               o_port_status,
    input  router_pipeline_bus_t    i_s2o,
    input  logic                    i_credit_ret,
    output router_pipeline_bus_t    o_flit,
    output logic                    o_flit_valid,
    output logic                    o_ovf_err
);

    localparam int PTR_W = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;
    localparam logic [PTR_W-1:0] RR_INIT =
        PTR_W'((PORT_ID + 1) % NUM_OF_PORTS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_OF_PORTS - 1);
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    opc_state_t state, state_nxt;

    logic [PTR_W-1:0]        rr_ptr, rr_nxt;
    logic [PTR_W-1:0]        win_idx, scan_idx;
    logic                    win_vld;
    logic [NUM_OF_PORTS-1:0] ack_nxt;

    router_pipeline_bus_t mem [2];
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           count, count_nxt;
    logic [3:0]           credits, credits_nxt;

    logic port_free;
    logic flit_in, flit_tail;
    logic push, pop_fifo, bypass, fire;
    logic wr_en, ovf_set;

    // Status is decoded from registered state only.
    assign port_free = (state == IDLE) && (count == 2'd0) &&
                       (credits != 4'd0) && (o_outport_ack == '0);

    always_comb begin
        o_port_status = '0;
        o_port_status.port_status = port_free ? PORT_FREE : PORT_BUSY;
    end

    assign flit_in   = i_s2o.flit.tail.flit_type != INVALID_FLIT;
    assign flit_tail = i_s2o.flit.tail.flit_type inside
                       {TAIL_FLIT, HEADTAIL_FLIT};

    assign push     = (state == ACTIVE) && flit_in;
    assign pop_fifo = (count != 2'd0) && (credits != 4'd0);
    // Empty FIFO with a credit: the arriving flit goes straight out.
    assign bypass   = push && (count == 2'd0) && (credits != 4'd0);
    assign fire     = pop_fifo || bypass;
    // A full FIFO still accepts a push when it pops in the same cycle.
    assign wr_en    = push && !bypass && ((count != 2'd2) || pop_fifo);
    assign ovf_set  = push && (count == 2'd2) && !pop_fifo;

    // Lowest offset from rr_ptr wins; scan from far to near.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = NUM_OF_PORTS - 1; i >= 0; i--) begin
            scan_idx = PTR_W'((int'(rr_ptr) + i) % NUM_OF_PORTS);
            if (i_outport_req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        ack_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (win_vld && port_free) begin
                    ack_nxt[win_idx] = 1'b1;
                    rr_nxt = (win_idx == LAST_IDX) ? '0
                                                   : win_idx + PTR_W'(1);
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (push && flit_tail) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (wr_en && !pop_fifo) begin
            count_nxt = count + 2'd1;
        end else if (!wr_en && pop_fifo) begin
            count_nxt = count - 2'd1;
        end

        credits_nxt = credits;
        if (fire && !i_credit_ret) begin
            credits_nxt = credits - 4'd1;
        end else if (!fire && i_credit_ret && (credits != CRED_MAX)) begin
            credits_nxt = credits + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= RR_INIT;
            o_outport_ack <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            credits       <= CRED_MAX;
            o_flit        <= invalid_flit();
            o_flit_valid  <= 1'b0;
            o_ovf_err     <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_nxt;
            o_outport_ack <= ack_nxt;
            count         <= count_nxt;
            credits       <= credits_nxt;
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_fifo) begin
                rd_ptr <= ~rd_ptr;
            end
            o_flit_valid <= fire;
            if (pop_fifo) begin
                o_flit <= mem[rd_ptr];
            end else if (bypass) begin
                o_flit <= i_s2o;
            end else begin
                o_flit <= invalid_flit();
            end
            if (ovf_set) begin
                o_ovf_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_s2o;
        end
    end

endmodule

// File: tb/tb_output_port_ctrl.sv
// Directed bench for output_port_ctrl: reset, arbitration, streaming,
// credit stall/overflow, credit bookkeeping and mid-packet reset.

module tb_output_port_ctrl;
    import router_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [4:0]           req_a, ack_a, req_b, ack_b;
    OUT_PORT_t            st_a, st_b;
    router_pipeline_bus_t s2o_a, s2o_b, flit_a, flit_b;
    logic                 ret_a, ret_b, fv_a, fv_b, ovf_a, ovf_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    output_port_ctrl #(.NUM_OF_PORTS(5), .PORT_ID(0), .CREDITS(4)) dut_a (
        .clk(clk), .rst(rst),
        .i_outport_req(req_a), .o_outport_ack(ack_a),
        .o_port_status(st_a), .i_s2o(s2o_a),
        .i_credit_ret(ret_a), .o_flit(flit_a),
        .o_flit_valid(fv_a), .o_ovf_err(ovf_a)
    );

    output_port_ctrl #(.NUM_OF_PORTS(5), .PORT_ID(0), .CREDITS(1)) dut_b (
        .clk(clk), .rst(rst),
        .i_outport_req(req_b), .o_outport_ack(ack_b),
        .o_port_status(st_b), .i_s2o(s2o_b),
        .i_credit_ret(ret_b), .o_flit(flit_b),
        .o_flit_valid(fv_b), .o_ovf_err(ovf_b)
    );

    function automatic router_pipeline_bus_t mk(flit_type_t t,
                                                logic [31:0] p);
        router_pipeline_bus_t f;
        f = '0;
        f.flit.tail.flit_type = t;
        f.flit.tail.payload   = p;
        return f;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_a = '0; req_b = '0;
        s2o_a = invalid_flit(); s2o_b = invalid_flit();
        ret_a = 1'b0; ret_b = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ack_a !== 5'b0) begin
            failures++; $display("FAIL rst_ack got=%b exp=0", ack_a);
        end
        checks++;
        if (fv_a !== 1'b0) begin
            failures++; $display("FAIL rst_valid got=%b exp=0", fv_a);
        end
        checks++;
        if (dut_a.credits !== 4'd4) begin
            failures++;
            $display("FAIL rst_credits got=%0d exp=4", dut_a.credits);
        end
        checks++;
        if (st_a.port_status !== PORT_FREE) begin
            failures++; $display("FAIL rst_status got=%b exp=FREE", st_a);
        end
        checks++;
        if (ovf_a !== 1'b0) begin
            failures++; $display("FAIL rst_ovf got=%b exp=0", ovf_a);
        end
        checks++;
        if (flit_a !== invalid_flit()) begin
            failures++; $display("FAIL rst_flit got=%h exp=invalid", flit_a);
        end
        checks++;
        if (dut_b.credits !== 4'd1) begin
            failures++;
            $display("FAIL rst_credits_b got=%0d exp=1", dut_b.credits);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        req_a = 5'b00110;
        cyc();
        checks++;
        if (ack_a !== 5'b00010) begin
            failures++; $display("FAIL arb_first got=%b exp=00010", ack_a);
        end
        checks++;
        if (st_a.port_status !== PORT_BUSY) begin
            failures++; $display("FAIL arb_busy got=%b exp=BUSY", st_a);
        end
        s2o_a = mk(HEAD_FLIT, 32'h11);
        cyc();
        checks++;
        if (ack_a !== 5'b0) begin
            failures++; $display("FAIL arb_pulse got=%b exp=0", ack_a);
        end
        checks++;
        if (fv_a !== 1'b1 || flit_a !== mk(HEAD_FLIT, 32'h11)) begin
            failures++;
            $display("FAIL arb_head got=%b/%h exp=1/head11", fv_a, flit_a);
        end
        s2o_a = mk(TAIL_FLIT, 32'h12);
        cyc();
        s2o_a = invalid_flit();
        checks++;
        if (ack_a !== 5'b0 || st_a.port_status !== PORT_FREE) begin
            failures++;
            $display("FAIL arb_tail got=%b/%b exp=0/FREE", ack_a, st_a);
        end
        cyc();
        checks++;
        if (ack_a !== 5'b00100) begin
            failures++; $display("FAIL arb_second got=%b exp=00100", ack_a);
        end
        req_a = '0;
    endtask

    task automatic test_stream();
        flit_type_t  ty [4];
        ty[0] = HEAD_FLIT; ty[1] = BODY_FLIT;
        ty[2] = BODY_FLIT; ty[3] = TAIL_FLIT;
        do_reset();
        req_a = 5'b00001;
        cyc();
        req_a = '0;
        checks++;
        if (ack_a !== 5'b00001) begin
            failures++; $display("FAIL str_ack got=%b exp=00001", ack_a);
        end
        for (int i = 0; i < 4; i++) begin
            s2o_a = mk(ty[i], 32'd100 + 32'(i));
            cyc();
            checks++;
            if (fv_a !== 1'b1 || flit_a !== mk(ty[i], 32'd100 + 32'(i)))
            begin
                failures++;
                $display("FAIL str_flit%0d got=%b/%h exp=1/%0d",
                         i, fv_a, flit_a, 100 + i);
            end
        end
        s2o_a = invalid_flit();
        checks++;
        if (dut_a.credits !== 4'd0) begin
            failures++;
            $display("FAIL str_credits got=%0d exp=0", dut_a.credits);
        end
        cyc();
        checks++;
        if (fv_a !== 1'b0 || st_a.port_status !== PORT_BUSY) begin
            failures++;
            $display("FAIL str_idle got=%b/%b exp=0/BUSY", fv_a, st_a);
        end
        ret_a = 1'b1;
        cyc();
        ret_a = 1'b0;
        checks++;
        if (dut_a.credits !== 4'd1 || st_a.port_status !== PORT_FREE) begin
            failures++;
            $display("FAIL str_return got=%0d/%b exp=1/FREE",
                     dut_a.credits, st_a);
        end
    endtask

    task automatic test_credit_stall();
        do_reset();
        req_b = 5'b00001;
        cyc();
        req_b = '0;
        s2o_b = mk(HEAD_FLIT, 32'd200);
        cyc();
        checks++;
        if (fv_b !== 1'b1 || flit_b !== mk(HEAD_FLIT, 32'd200)) begin
            failures++;
            $display("FAIL stl_head got=%b/%h exp=1/200", fv_b, flit_b);
        end
        s2o_b = mk(BODY_FLIT, 32'd201);
        cyc();
        s2o_b = mk(BODY_FLIT, 32'd202);
        cyc();
        checks++;
        if (fv_b !== 1'b0 || dut_b.count !== 2'd2 || ovf_b !== 1'b0) begin
            failures++;
            $display("FAIL stl_full got=%b/%0d/%b exp=0/2/0",
                     fv_b, dut_b.count, ovf_b);
        end
        s2o_b = mk(TAIL_FLIT, 32'd203);
        cyc();
        s2o_b = invalid_flit();
        checks++;
        if (ovf_b !== 1'b1 || dut_b.count !== 2'd2) begin
            failures++;
            $display("FAIL stl_ovf got=%b/%0d exp=1/2", ovf_b, dut_b.count);
        end
        ret_b = 1'b1;
        cyc();
        ret_b = 1'b0;
        checks++;
        if (fv_b !== 1'b0 || dut_b.credits !== 4'd1) begin
            failures++;
            $display("FAIL stl_ret got=%b/%0d exp=0/1", fv_b, dut_b.credits);
        end
        cyc();
        checks++;
        if (fv_b !== 1'b1 || flit_b !== mk(BODY_FLIT, 32'd201)) begin
            failures++;
            $display("FAIL stl_next got=%b/%h exp=1/201", fv_b, flit_b);
        end
        checks++;
        if (ovf_b !== 1'b1 || dut_b.count !== 2'd1) begin
            failures++;
            $display("FAIL stl_sticky got=%b/%0d exp=1/1", ovf_b, dut_b.count);
        end
    endtask

    task automatic test_credit_math();
        do_reset();
        req_a = 5'b00001;
        cyc();
        req_a = '0;
        s2o_a = mk(HEAD_FLIT, 32'd300);
        cyc();
        s2o_a = mk(BODY_FLIT, 32'd301);
        cyc();
        checks++;
        if (dut_a.credits !== 4'd2) begin
            failures++;
            $display("FAIL crd_two got=%0d exp=2", dut_a.credits);
        end
        s2o_a = mk(BODY_FLIT, 32'd302);
        ret_a = 1'b1;
        cyc();
        ret_a = 1'b0;
        checks++;
        if (dut_a.credits !== 4'd2 || fv_a !== 1'b1) begin
            failures++;
            $display("FAIL crd_both got=%0d/%b exp=2/1", dut_a.credits, fv_a);
        end
        s2o_a = mk(TAIL_FLIT, 32'd303);
        cyc();
        s2o_a = invalid_flit();
        ret_a = 1'b1;
        cyc(); cyc(); cyc();
        checks++;
        if (dut_a.credits !== 4'd4) begin
            failures++;
            $display("FAIL crd_refill got=%0d exp=4", dut_a.credits);
        end
        cyc();
        ret_a = 1'b0;
        checks++;
        if (dut_a.credits !== 4'd4) begin
            failures++;
            $display("FAIL crd_sat got=%0d exp=4", dut_a.credits);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 5'b00001;
        cyc();
        req_a = '0;
        for (int i = 0; i < 6; i++) begin
            s2o_a = mk((i == 0) ? HEAD_FLIT : BODY_FLIT, 32'd400 + 32'(i));
            cyc();
        end
        s2o_a = invalid_flit();
        checks++;
        if (dut_a.count !== 2'd2 || dut_a.state !== ACTIVE) begin
            failures++;
            $display("FAIL mid_pre got=%0d/%b exp=2/ACTIVE",
                     dut_a.count, dut_a.state);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (dut_a.count !== 2'd0 || dut_a.state !== IDLE) begin
            failures++;
            $display("FAIL mid_fifo got=%0d/%b exp=0/IDLE",
                     dut_a.count, dut_a.state);
        end
        checks++;
        if (fv_a !== 1'b0 || flit_a !== invalid_flit() ||
            dut_a.credits !== 4'd4) begin
            failures++;
            $display("FAIL mid_out got=%b/%h/%0d exp=0/invalid/4",
                     fv_a, flit_a, dut_a.credits);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (fv_a !== 1'b0) begin
                failures++; $display("FAIL mid_quiet%0d got=%b exp=0", i, fv_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_stream();
        test_credit_stall();
        test_credit_math();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
